// File: rtl/ps2_pkg.sv
// Shared constants, frame state encoding and control-byte classification
// for the PS/2 scan-code set 2 decoder.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // Keyboard housekeeping bytes that never map to a key.
  localparam int               PS2_NUM_IGNORED = 6;
  localparam logic [5:0][7:0]  PS2_IGNORED     = {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_e;

  function automatic logic is_ignored(input logic [7:0] b);
    is_ignored = 1'b0;
    for (int i = 0; i < PS2_NUM_IGNORED; i++)
      if (b == PS2_IGNORED[i]) is_ignored = 1'b1;
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchronizer followed by a level filter: the output only moves
// after the synchronized input has disagreed with it for FILTER_LEN cycles.
module ps2_sync_filter #(
  parameter int   FILTER_LEN = 8,
  parameter logic RST_VAL    = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [1:0] sync_q;
  logic [7:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {2{RST_VAL}};
      dout   <= RST_VAL;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], din};
      if (sync_q[1] == dout)
        cnt_q <= '0;
      else if (cnt_q == 8'(FILTER_LEN - 1)) begin
        dout  <= sync_q[1];
        cnt_q <= '0;
      end else
        cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: frames bits on filtered clock edges, then turns
// scan-code set 2 bytes (with F0/E0 prefixes) into one-cycle key events.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN      = 8,
  parameter int TIMEOUT_CYCLES  = 50000,
  parameter bit SUPPRESS_REPEAT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       key_is_press,
  output logic       key_ext,
  output logic       key_en,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic clk_f, clk_f_q, data_s, fall;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN), .RST_VAL(1'b1)) u_clk_filt (
    .clk(clk), .reset(reset), .din(ps2_clk), .dout(clk_f));
  ps2_sync_filter #(.FILTER_LEN(1), .RST_VAL(1'b1)) u_data_sync (
    .clk(clk), .reset(reset), .din(ps2_data), .dout(data_s));

  assign fall = clk_f_q & ~clk_f;

  frame_state_e state_q, state_d;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg, byte_q;
  logic          par_q;
  logic [TW-1:0] tmo_cnt;
  logic          byte_ok, byte_bad, tmo;
  logic          byte_stb, bad_stb, tmo_stb;

  always_comb begin
    state_d  = state_q;
    byte_ok  = 1'b0;
    byte_bad = 1'b0;
    tmo      = 1'b0;
    if (fall) begin
      unique case (state_q)
        IDLE:   if (!data_s) state_d = DATA;
        DATA:   if (bit_cnt == 3'd7) state_d = PARITY;
        PARITY: state_d = STOP;
        STOP: begin
          state_d = IDLE;
          if (data_s && (^shreg ^ par_q)) byte_ok = 1'b1;
          else byte_bad = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tmo_cnt == TW'(TIMEOUT_CYCLES)) begin
      state_d = IDLE;
      tmo     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      clk_f_q  <= 1'b1;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_q    <= 1'b0;
      tmo_cnt  <= '0;
      byte_q   <= '0;
      byte_stb <= 1'b0;
      bad_stb  <= 1'b0;
      tmo_stb  <= 1'b0;
    end else begin
      state_q  <= state_d;
      clk_f_q  <= clk_f;
      byte_stb <= byte_ok;
      bad_stb  <= byte_bad;
      tmo_stb  <= tmo;
      if (byte_ok) byte_q <= shreg;
      tmo_cnt  <= (state_q == IDLE || fall) ? '0 : tmo_cnt + 1'b1;
      if (fall) begin
        unique case (state_q)
          IDLE: bit_cnt <= '0;
          DATA: begin
            shreg   <= {data_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY: par_q <= data_s;
          default: ;
        endcase
      end
    end
  end

  logic       brk_pend, ext_pend;
  logic [7:0] held_code;
  logic       held_ext, held_valid, held_match, drop;

  assign held_match = held_valid && held_code == byte_q && held_ext == ext_pend;
  assign drop       = SUPPRESS_REPEAT && !brk_pend && held_match;

  always_ff @(posedge clk) begin
    if (reset) begin
      keycode      <= '0;
      key_is_press <= 1'b0;
      key_ext      <= 1'b0;
      key_en       <= 1'b0;
      frame_err    <= 1'b0;
      brk_pend     <= 1'b0;
      ext_pend     <= 1'b0;
      held_code    <= '0;
      held_ext     <= 1'b0;
      held_valid   <= 1'b0;
    end else begin
      key_en    <= 1'b0;
      frame_err <= bad_stb;
      if (bad_stb || tmo_stb) begin
        brk_pend <= 1'b0;
        ext_pend <= 1'b0;
      end else if (byte_stb) begin
        if (byte_q == PS2_BREAK)
          brk_pend <= 1'b1;
        else if (byte_q == PS2_EXT)
          ext_pend <= 1'b1;
        else begin
          brk_pend <= 1'b0;
          ext_pend <= 1'b0;
          if (!is_ignored(byte_q) && !drop) begin
            key_en       <= 1'b1;
            keycode      <= byte_q;
            key_is_press <= ~brk_pend;
            key_ext      <= ext_pend;
            if (!brk_pend) begin
              held_code  <= byte_q;
              held_ext   <= ext_pend;
              held_valid <= 1'b1;
            end else if (held_match)
              held_valid <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench: a PS/2 bit-level driver, a table of byte sequences with
// expected events, and hand-written sequences for errors, timeout, glitch, reset.
module tb_ps2_key_decoder;

  localparam int F   = 8;
  localparam int TMO = 300;
  localparam int H   = 25;

  logic       clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [7:0] keycode;
  logic       key_is_press, key_ext, key_en, frame_err;

  ps2_key_decoder #(.FILTER_LEN(F), .TIMEOUT_CYCLES(TMO), .SUPPRESS_REPEAT(1'b1)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keycode(keycode), .key_is_press(key_is_press), .key_ext(key_ext),
    .key_en(key_en), .frame_err(frame_err));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int         ev_cnt = 0, err_cnt = 0, ev_cyc = 0, stop_cyc = 0;
  logic [7:0] ev_code = '0;
  logic       ev_press = 1'b0, ev_ext = 1'b0;

  always @(negedge clk) begin
    if (key_en) begin
      ev_cnt++;
      ev_cyc   = cyc;
      ev_code  = keycode;
      ev_press = key_is_press;
      ev_ext   = key_ext;
    end
    if (frame_err) err_cnt++;
  end

  int total = 0, bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic par_flip,
                                             input logic stop);
    return {stop, (~^b) ^ par_flip, b, 1'b0};
  endfunction

  // Bits go out LSB first; data changes while the clock is high.
  task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch_bit);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      if (i == glitch_bit) begin
        idle(5); ps2_clk = 1'b0; idle(3); ps2_clk = 1'b1; idle(H - 8);
      end else
        idle(H);
      ps2_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      idle(H);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(frame_bits(b, 1'b0, 1'b1), 11, -1);
    idle(40);
  endtask

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         n;
    int         exp_ev;
    logic [7:0] code;
    logic       press, ext;
  } vec_t;

  vec_t vt[10];

  initial begin
    #2ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench timed out");
  end

  initial begin
    int e0, r0;
    vt[0] = '{8'hF0, 8'h15, 8'h00, 2, 1, 8'h15, 1'b0, 1'b0};
    vt[1] = '{8'hE0, 8'h74, 8'h00, 2, 1, 8'h74, 1'b1, 1'b1};
    vt[2] = '{8'hE0, 8'hF0, 8'h74, 3, 1, 8'h74, 1'b0, 1'b1};
    vt[3] = '{8'hAA, 8'h00, 8'h00, 1, 0, 8'h00, 1'b0, 1'b0};
    vt[4] = '{8'h1C, 8'h00, 8'h00, 1, 1, 8'h1C, 1'b1, 1'b0};
    vt[5] = '{8'hF0, 8'hAA, 8'h1C, 3, 0, 8'h00, 1'b0, 1'b0};
    vt[6] = '{8'hF0, 8'h1C, 8'h00, 2, 1, 8'h1C, 1'b0, 1'b0};
    vt[7] = '{8'h74, 8'h00, 8'h00, 1, 1, 8'h74, 1'b1, 1'b0};
    vt[8] = '{8'hE0, 8'h74, 8'h00, 2, 1, 8'h74, 1'b1, 1'b1};
    vt[9] = '{8'hE0, 8'hF0, 8'h74, 3, 1, 8'h74, 1'b0, 1'b1};

    idle(5);
    chk("rst_keycode", int'(keycode), 0);
    chk("rst_press", int'(key_is_press), 0);
    chk("rst_ext", int'(key_ext), 0);
    chk("rst_key_en", int'(key_en), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    reset = 1'b0;
    idle(20);

    // Simple press with latency from stop-bit falling edge.
    e0 = ev_cnt;
    send_byte(8'h15);
    chk("press_cnt", ev_cnt - e0, 1);
    chk("press_code", int'(ev_code), 'h15);
    chk("press_is_press", int'(ev_press), 1);
    chk("press_ext", int'(ev_ext), 0);
    chk("press_latency", ev_cyc - stop_cyc, F + 4);

    for (int v = 0; v < 10; v++) begin
      e0 = ev_cnt; r0 = err_cnt;
      send_byte(vt[v].b0);
      if (vt[v].n > 1) send_byte(vt[v].b1);
      if (vt[v].n > 2) send_byte(vt[v].b2);
      chk($sformatf("vec%0d_cnt", v), ev_cnt - e0, vt[v].exp_ev);
      chk($sformatf("vec%0d_err", v), err_cnt - r0, 0);
      if (vt[v].exp_ev != 0) begin
        chk($sformatf("vec%0d_code", v), int'(ev_code), int'(vt[v].code));
        chk($sformatf("vec%0d_press", v), int'(ev_press), int'(vt[v].press));
        chk($sformatf("vec%0d_ext", v), int'(ev_ext), int'(vt[v].ext));
      end
    end

    // Bad parity, bad stop, then recovery.
    e0 = ev_cnt; r0 = err_cnt;
    send_bits(frame_bits(8'h1C, 1'b1, 1'b1), 11, -1); idle(40);
    chk("parity_err", err_cnt - r0, 1);
    chk("parity_no_ev", ev_cnt - e0, 0);
    r0 = err_cnt;
    send_bits(frame_bits(8'h1C, 1'b0, 1'b0), 11, -1); idle(40);
    chk("stop_err", err_cnt - r0, 1);
    chk("stop_no_ev", ev_cnt - e0, 0);
    send_byte(8'h1C);
    chk("recover_cnt", ev_cnt - e0, 1);
    chk("recover_code", int'(ev_code), 'h1C);
    chk("recover_press", int'(ev_press), 1);
    send_byte(8'hF0); send_byte(8'h1C);
    chk("release_1c", int'(ev_press), 0);

    // Break prefix is dropped by a bad frame.
    e0 = ev_cnt; r0 = err_cnt;
    send_byte(8'hF0);
    send_bits(frame_bits(8'h1C, 1'b1, 1'b1), 11, -1); idle(40);
    send_byte(8'h1C);
    chk("brkclr_err", err_cnt - r0, 1);
    chk("brkclr_cnt", ev_cnt - e0, 1);
    chk("brkclr_press", int'(ev_press), 1);

    // Partial frame abandoned by timeout; prefix also cleared.
    e0 = ev_cnt; r0 = err_cnt;
    send_byte(8'hF0);
    send_bits(frame_bits(8'h55, 1'b0, 1'b1), 5, -1);
    idle(TMO + 10);
    send_byte(8'h24);
    chk("tmo_cnt", ev_cnt - e0, 1);
    chk("tmo_code", int'(ev_code), 'h24);
    chk("tmo_press", int'(ev_press), 1);
    chk("tmo_no_err", err_cnt - r0, 0);

    // Typematic repeat suppression.
    e0 = ev_cnt;
    repeat (3) send_byte(8'h15);
    chk("rep_cnt", ev_cnt - e0, 1);
    chk("rep_code", int'(ev_code), 'h15);
    send_byte(8'hF0); send_byte(8'h15);
    chk("rep_rel_cnt", ev_cnt - e0, 2);
    chk("rep_rel_press", int'(ev_press), 0);
    send_byte(8'h15);
    chk("rep_again_cnt", ev_cnt - e0, 3);
    chk("rep_again_press", int'(ev_press), 1);

    // Short low glitches inside a frame and on an idle bus.
    e0 = ev_cnt; r0 = err_cnt;
    send_bits(frame_bits(8'h2D, 1'b0, 1'b1), 11, 3); idle(40);
    chk("glitch_cnt", ev_cnt - e0, 1);
    chk("glitch_code", int'(ev_code), 'h2D);
    ps2_clk = 1'b0; idle(3); ps2_clk = 1'b1; idle(100);
    chk("glitch_idle_ev", ev_cnt - e0, 1);
    chk("glitch_idle_err", err_cnt - r0, 0);

    // Reset after the 5th data bit.
    send_bits(frame_bits(8'h33, 1'b0, 1'b1), 6, -1);
    reset = 1'b1; idle(1); reset = 1'b0;
    chk("midrst_keycode", int'(keycode), 0);
    chk("midrst_press", int'(key_is_press), 0);
    chk("midrst_ext", int'(key_ext), 0);
    idle(100);
    e0 = ev_cnt; r0 = err_cnt;
    send_byte(8'h1D);
    chk("midrst_cnt", ev_cnt - e0, 1);
    chk("midrst_code", int'(ev_code), 'h1D);
    chk("midrst_is_press", int'(ev_press), 1);
    chk("midrst_err", err_cnt - r0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Receives the raw PS/2 keyboard clock/data lines and turns scan-code set 2 byte streams into key events for `event_buffer`. Produces `keycode`, `key_is_press` and a one-cycle `key_en` strobe. Handles break (F0) and extended (E0) prefixes, frame errors, timeouts and typematic auto-repeat. Sits directly upstream of `event_buffer`, which feeds `processor`.

## Interface
- `FILTER_LEN`, 8: cycles `ps2_clk` must hold a level before the new level is accepted; range 1..255.
- `TIMEOUT_CYCLES`, 50000: clock cycles without a filtered falling edge before a partial frame is abandoned (1 ms at 50 MHz).
- `SUPPRESS_REPEAT`, 1: when 1, a repeated make code for the currently held key is dropped.
- `clk`  in  1: system clock; the only clock.
- `reset`  in  1: synchronous, active-high.
- `ps2_clk`  in  1: raw keyboard clock pin, asynchronous.
- `ps2_data`  in  1: raw keyboard data pin, asynchronous.
- `keycode`  out  8: last emitted scan code; held between events.
- `key_is_press`  out  1: 1 = make, 0 = break; valid with `key_en`, held after.
- `key_ext`  out  1: event was E0-prefixed; valid with `key_en`, held after.
- `key_en`  out  1: one-cycle event strobe.
- `frame_err`  out  1: one-cycle pulse on a parity or stop-bit error.

## Operation
- **Input conditioning:** both pins pass through a 2-flop synchronizer. `ps2_clk` is then filtered: the output level changes only after the synchronized input differs from it for `FILTER_LEN` consecutive cycles. A falling edge is detected on the filtered clock. Data is sampled from the synchronized `ps2_data` in the falling-edge cycle.
- **Frame FSM:** IDLE → DATA → PARITY → STOP → IDLE.
  - IDLE: on an edge with data=0 (start bit), clear the bit counter and go to DATA. A start bit of 1 is ignored and the FSM stays in IDLE.
  - DATA: shift 8 bits, LSB first; after the 8th bit go to PARITY.
  - PARITY: store the bit; go to STOP.
  - STOP: the byte is good if the stop bit is 1 and the XOR of the 8 data bits and the parity bit is 1 (odd parity). Either way, return to IDLE.
- **Bad frame:** pulse `frame_err`, discard the byte, clear the break and extended prefix flags.
- **Timeout:** in any state other than IDLE, a counter reloads on every filtered falling edge. When it reaches `TIMEOUT_CYCLES`, the FSM goes to IDLE, drops the partial byte and clears the prefix flags. No `frame_err` is raised for a timeout.
- **Good byte handling:**
  - 0xF0: set break_pending.
  - 0xE0: set ext_pending.
  - 0xAA, 0xFA, 0xFE, 0xEE, 0x00, 0xFF: discarded; prefix flags cleared.
  - Any other byte: an event with code = byte, press = ~break_pending, ext = ext_pending; then clear both flags.
- **Repeat filter (`SUPPRESS_REPEAT`=1):** the block tracks `held_code`, `held_ext` and `held_valid`.
  - A press matching the held {code, ext} while `held_valid` is 1 is dropped.
  - Any other press is emitted and becomes the held key.
  - A release matching the held key clears `held_valid`.
  - Releases are always emitted.
- **Reset values:** all outputs 0, FSM in IDLE, prefix flags and `held_valid` cleared. The filter output resets to 1 (bus idle level). A reset mid-frame discards the frame.

## Timing
- `key_en` and `frame_err` are high for exactly one cycle. Two strobes are always at least one full PS/2 frame apart.
- `keycode`, `key_is_press` and `key_ext` update in the same cycle that `key_en` rises, and are held until the next event.
- Latency from the raw `ps2_clk` falling transition of the stop bit to `key_en` high is `FILTER_LEN`+4 cycles: 2 sync, `FILTER_LEN` filter, 1 edge detect, 1 registered output.
- A timeout and a falling edge in the same cycle: the edge wins and the counter reloads.
- Reset asserted in the same cycle as an output strobe: the strobe is suppressed.
- Glitches on `ps2_clk` shorter than `FILTER_LEN` cycles produce no edge.
- `event_buffer` must accept one event per `key_en`. No back-pressure exists; PS/2 frame spacing (≥ 500 µs) bounds the event rate.

## Structure
- **Package `ps2_pkg`:**
  - constants `PS2_BREAK` = 8'hF0 and `PS2_EXT` = 8'hE0;
  - the list of ignored control bytes;
  - the frame state enum (IDLE, DATA, PARITY, STOP).
- **Sub-module `ps2_sync_filter`:** a 2-flop synchronizer plus a `FILTER_LEN` stability counter, with a reset value parameter.
  - Instantiated for `ps2_clk` with filtering.
  - Instantiated for `ps2_data` with `FILTER_LEN`=1, i.e. synchronize only.

## Test plan
- **Simple press:** BFM sends frame 0x15 with odd parity, 60 µs bit period → single `key_en`, keycode 0x15, `key_is_press`=1, `key_ext`=0, exactly `FILTER_LEN`+4 cycles after the stop-bit falling edge.
- **Break and extended:**
  - F0,15 → keycode 0x15, press=0.
  - E0,74 → keycode 0x74, press=1, ext=1.
  - E0,F0,74 → keycode 0x74, press=0, ext=1.
  - No `key_en` is produced for any prefix byte.
- **Bad frames and recovery:**
  - Frame 0x1C with wrong parity → `frame_err` pulse, no `key_en`.
  - Frame with stop bit 0 → `frame_err` pulse.
  - Next good 0x1C → normal event.
  - F0 followed by a bad frame, then 0x1C → press=1, because the prefix was cleared.
- **Timeout:** send start plus 4 bits, idle `TIMEOUT_CYCLES`+10 cycles, then a full frame 0x24 → exactly one event, 0x24, press=1; no `frame_err`.
- **Repeat and glitch:**
  - 0x15 three times → one `key_en`. Then F0,15 → release event. Then 0x15 → press event again.
  - A 3-cycle low glitch on `ps2_clk` (`FILTER_LEN`=8) → no state change.
- **Reset mid-frame:** `reset` asserted for 1 cycle after the 5th data bit → all outputs 0. A following complete frame 0x1D decodes correctly.
